// File: rtl/seq_replayer.sv
// rtl/seq_replayer.sv - multi-mode address sequence replayer for the pattern memory
//
// Steps seq through 0..max(limit,1)-1 every period+1 cycles in loop, one-shot
// or ping-pong order, pulsing read_o at each step and ready_o one cycle later.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable_i   1 = advance and drive addr_o, 0 = pause and release addr_o
//   start_i    (re)start pulse, latches mode_i, fetches address 0 at once
//   stop_i     return to idle
//   mode_i     00 loop, 01 one-shot, 10 ping-pong, 11 loop
//   limit_i    sequence length (0 behaves as 1), sampled live
//   period_i   step interval minus one, sampled live
//   read_o     one-cycle memory read strobe
//   ready_o    read_o delayed by one cycle
//   busy_o     high while running
//   done_o     one-cycle pulse when a one-shot run completes
//   addr_o     current sequence value while enabled, high-Z otherwise

module seq_replayer #(
    parameter int ADDR_W   = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [1:0]          mode_i,
    input  logic [ADDR_W-1:0]   limit_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                read_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   seq_q;
    logic [ADDR_W-1:0]   seq_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic                dir_q;   // 0 = counting up, 1 = counting down
    logic                dir_d;
    logic [1:0]          mode_q;
    logic                read_q;
    logic                ready_q;
    logic                done_q;
    logic                busy_q;

    logic [ADDR_W-1:0]   end_w;
    logic                at_end_w;
    logic                tick_w;
    logic                finish_w;

    // Last valid index; limit 0 collapses to a one-entry sequence.
    assign end_w    = (limit_i == '0) ? '0 : limit_i - 1'b1;
    // >= rather than == so a limit lowered below seq ends the range at the next tick.
    assign at_end_w = (seq_q >= end_w);
    assign tick_w   = (cnt_q == period_i);

    // Successor of seq for the latched traversal mode.
    always_comb begin
        seq_d    = seq_q;
        dir_d    = dir_q;
        finish_w = 1'b0;
        unique case (mode_q)
            2'b01: begin
                if (at_end_w) finish_w = 1'b1;
                else          seq_d    = seq_q + 1'b1;
            end
            2'b10: begin
                if (!dir_q) begin
                    if (at_end_w) begin
                        dir_d = 1'b1;
                        seq_d = (end_w == '0) ? '0 : end_w - 1'b1;
                    end else begin
                        seq_d = seq_q + 1'b1;
                    end
                end else begin
                    if (seq_q == '0) begin
                        dir_d = 1'b0;
                        seq_d = (end_w == '0) ? '0 : {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        seq_d = seq_q - 1'b1;
                    end
                end
            end
            default: seq_d = at_end_w ? '0 : seq_q + 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            read_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            read_q  <= 1'b0;
            ready_q <= read_q;
            done_q  <= 1'b0;
            if (start_i) begin
                // Address 0 is fetched straight away, even while paused.
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                seq_q   <= '0;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
                mode_q  <= mode_i;
                read_q  <= 1'b1;
            end else if (stop_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == S_RUN && enable_i) begin
                if (tick_w) begin
                    cnt_q <= '0;
                    if (finish_w) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        seq_q  <= seq_d;
                        dir_q  <= dir_d;
                        read_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign read_o  = read_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign addr_o  = enable_i ? seq_q : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_seq_replayer.sv
// tb/tb_seq_replayer.sv - self-checking bench for seq_replayer

module tb_seq_replayer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  limit = 8'd0;
    logic [23:0] period = 24'd0;
    wire         read_w;
    wire         ready_w;
    wire         busy_w;
    wire         done_w;
    wire  [7:0]  addr_w;

    seq_replayer #(.ADDR_W(8), .PERIOD_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .start_i(start), .stop_i(stop),
        .mode_i(mode), .limit_i(limit), .period_i(period),
        .read_o(read_w), .ready_o(ready_w), .busy_o(busy_w), .done_o(done_w), .addr_o(addr_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        en, st, sp;
        bit [1:0]  md;
        bit [7:0]  lim;
        bit [23:0] per;
        bit        e_read, e_ready, e_busy, e_done;
        bit [7:0]  e_addr;
    } vec_t;

    function automatic vec_t mk(bit st, bit sp, bit [1:0] md, bit [7:0] lim, bit [23:0] per,
                                bit r, bit y, bit b, bit d, bit [7:0] a);
        vec_t v;
        v.en = 1'b1; v.st = st; v.sp = sp; v.md = md; v.lim = lim; v.per = per;
        v.e_read = r; v.e_ready = y; v.e_busy = b; v.e_done = d; v.e_addr = a;
        return v;
    endfunction

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: step index k and interval counter, address derived arithmetically.
    int       k, mcnt, mL, mper;
    bit       mrun;
    bit [1:0] mmode;
    bit       e_read, e_ready, e_busy, e_done;

    function automatic int exp_addr(int kk, int L, bit [1:0] m);
        int p;
        if (m == 2'b10) begin
            if (L <= 1) return 0;
            p = kk % (2 * (L - 1));
            return (p < L) ? p : 2 * (L - 1) - p;
        end
        if (m == 2'b01) return kk;
        return kk % L;
    endfunction

    task automatic model_reset();
        k = 0; mcnt = 0; mL = 1; mper = 0; mrun = 0; mmode = 2'b00;
        e_read = 0; e_ready = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic model_step();
        e_ready = e_read;
        e_read  = 0;
        e_done  = 0;
        if (start) begin
            k = 0; mcnt = 0; mrun = 1; e_busy = 1; mmode = mode;
            mL = (limit == 0) ? 1 : int'(limit);
            mper = int'(period);
            e_read = 1;
        end else if (stop) begin
            mrun = 0; e_busy = 0; mcnt = 0;
        end else if (mrun && enable) begin
            if (mcnt == mper) begin
                mcnt = 0;
                if (mmode == 2'b01 && k >= mL - 1) begin
                    mrun = 0; e_busy = 0; e_done = 1;
                end else begin
                    k++;
                    e_read = 1;
                end
            end else begin
                mcnt++;
            end
        end
    endtask

    vec_t vq[$];

    initial begin
        int rd_seen;

        // ---------------- reset state ----------------
        enable = 1'b1;
        #12;
        check("reset read", read_w, 0);
        check("reset ready", ready_w, 0);
        check("reset busy", busy_w, 0);
        check("reset done", done_w, 0);
        check("reset addr", addr_w, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        // Loop: limit 3, period 2
        vq.push_back(mk(1,0,2'b00,3,2, 1,0,1,0,0));
        vq.push_back(mk(0,0,2'b00,3,2, 0,1,1,0,0));
        vq.push_back(mk(0,0,2'b00,3,2, 0,0,1,0,0));
        vq.push_back(mk(0,0,2'b00,3,2, 1,0,1,0,1));
        vq.push_back(mk(0,0,2'b00,3,2, 0,1,1,0,1));
        vq.push_back(mk(0,0,2'b00,3,2, 0,0,1,0,1));
        vq.push_back(mk(0,0,2'b00,3,2, 1,0,1,0,2));
        vq.push_back(mk(0,0,2'b00,3,2, 0,1,1,0,2));
        vq.push_back(mk(0,0,2'b00,3,2, 0,0,1,0,2));
        vq.push_back(mk(0,0,2'b00,3,2, 1,0,1,0,0));
        vq.push_back(mk(0,0,2'b00,3,2, 0,1,1,0,0));
        // One-shot: limit 4, period 0
        vq.push_back(mk(1,0,2'b01,4,0, 1,0,1,0,0));
        vq.push_back(mk(0,0,2'b01,4,0, 1,1,1,0,1));
        vq.push_back(mk(0,0,2'b01,4,0, 1,1,1,0,2));
        vq.push_back(mk(0,0,2'b01,4,0, 1,1,1,0,3));
        vq.push_back(mk(0,0,2'b01,4,0, 0,1,0,1,3));
        vq.push_back(mk(0,0,2'b01,4,0, 0,0,0,0,3));
        vq.push_back(mk(0,0,2'b01,4,0, 0,0,0,0,3));
        // Start+stop together, limit 0 behaves as 1, then stop
        vq.push_back(mk(1,1,2'b00,0,0, 1,0,1,0,0));
        vq.push_back(mk(0,0,2'b00,0,0, 1,1,1,0,0));
        vq.push_back(mk(0,1,2'b00,0,0, 0,1,0,0,0));
        vq.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,0));
        // Ping-pong: limit 3, period 0 -> 0,1,2,1,0,1,2
        vq.push_back(mk(1,0,2'b10,3,0, 1,0,1,0,0));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,1));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,2));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,1));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,0));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,1));
        vq.push_back(mk(0,0,2'b10,3,0, 1,1,1,0,2));
        // Ping-pong limit 1: constant 0 with a read every cycle, then stop
        vq.push_back(mk(1,0,2'b10,1,0, 1,1,1,0,0));
        vq.push_back(mk(0,0,2'b10,1,0, 1,1,1,0,0));
        vq.push_back(mk(0,0,2'b10,1,0, 1,1,1,0,0));
        vq.push_back(mk(0,1,2'b10,1,0, 0,1,0,0,0));

        foreach (vq[i]) begin
            enable = vq[i].en; start = vq[i].st; stop = vq[i].sp;
            mode = vq[i].md; limit = vq[i].lim; period = vq[i].per;
            cycle();
            check($sformatf("vec%0d read", i), read_w, vq[i].e_read);
            check($sformatf("vec%0d ready", i), ready_w, vq[i].e_ready);
            check($sformatf("vec%0d busy", i), busy_w, vq[i].e_busy);
            check($sformatf("vec%0d done", i), done_w, vq[i].e_done);
            check($sformatf("vec%0d addr", i), addr_w, vq[i].e_addr);
        end
        start = 0; stop = 0;

        // ---------------- pause mid-interval ----------------
        enable = 1; mode = 2'b00; limit = 5; period = 4; start = 1;
        cycle();
        start = 0;
        check("pause first read", read_w, 1);
        cycle(); cycle();                   // cnt now 2
        enable = 0;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            rd_seen += read_w;
            check("pause busy", busy_w, 1);
        end
        check("pause no reads", rd_seen, 0);
        enable = 1;
        cycle(); check("resume c1 read", read_w, 0);
        cycle(); check("resume c2 read", read_w, 0);
        cycle(); check("resume c3 read", read_w, 1);
        check("resume addr", addr_w, 1);

        // ---------------- limit lowered mid-run ----------------
        limit = 6; period = 0; mode = 2'b00; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("loop lowered pre addr", addr_w, 4);
        limit = 2;
        cycle();
        check("loop lowered wrap addr", addr_w, 0);
        check("loop lowered wrap read", read_w, 1);

        limit = 6; mode = 2'b01; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("oneshot lowered pre addr", addr_w, 3);
        limit = 2;
        cycle();
        check("oneshot lowered done", done_w, 1);
        check("oneshot lowered read", read_w, 0);
        check("oneshot lowered busy", busy_w, 0);
        check("oneshot lowered addr", addr_w, 3);

        // ---------------- async reset mid-run ----------------
        limit = 4; period = 0; mode = 2'b00; start = 1;
        cycle(); start = 0;
        cycle(); cycle();
        #2 rst_n = 0;
        #1;
        check("async rst read", read_w, 0);
        check("async rst ready", ready_w, 0);
        check("async rst busy", busy_w, 0);
        check("async rst addr", addr_w, 0);
        cycle();
        rst_n = 1;
        rd_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            rd_seen += read_w + busy_w;
        end
        check("post rst idle", rd_seen, 0);

        // ---------------- randomized run against the model ----------------
        rst_n = 0;
        cycle();
        rst_n = 1;
        model_reset();
        limit = 3; period = 0;
        for (int c = 0; c < 3000; c++) begin
            start  = ($urandom_range(0, 99) < 3);
            stop   = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 99) < 85);
            mode   = 2'($urandom_range(0, 3));
            if (start) begin
                limit  = 8'($urandom_range(0, 9));
                period = 24'($urandom_range(0, 3));
            end
            cycle();
            model_step();
            check("rnd read", read_w, e_read);
            check("rnd ready", ready_w, e_ready);
            check("rnd busy", busy_w, e_busy);
            check("rnd done", done_w, e_done);
            if (enable) check("rnd addr", addr_w, exp_addr(k, mL, mmode));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
